// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column synchroniser, tick-paced row scan, press/release
// debounce and held key code. Define KB_PULSE_EN to add the one-cycle kb_press strobe.
`ifndef KBCODE_WID
`define KBCODE_WID 5
`endif

module keypad_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int DEB_CYC  = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             col_in,
  output logic [3:0]             row_out,
  output logic [`KBCODE_WID-1:0] kb_idx
`ifdef KB_PULSE_EN
  ,
  output logic                   kb_press
`endif
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DEBOUNCE, PRESSED} state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [DEB_W-1:0]        deb_q, deb_d;
  logic [1:0]              row_q, row_d;
  logic [1:0]              cand_q, cand_d;
  logic [3:0]              sync1_q, col_s_q;
  logic [3:0]              row_out_q, row_out_d;
  logic [`KBCODE_WID-1:0]  kb_idx_q, kb_idx_d;
  logic                    tick;
  logic                    any_low, one_low, match;
  logic [1:0]              low_col;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign tick = (div_q == DIV_LAST);

  // Classify the synchronised columns: none, exactly one, or several pulled low.
  always_comb begin
    any_low = (col_s_q != 4'hF);
    one_low = 1'b0;
    low_col = 2'd0;
    case (col_s_q)
      4'b1110: begin one_low = 1'b1; low_col = 2'd0; end
      4'b1101: begin one_low = 1'b1; low_col = 2'd1; end
      4'b1011: begin one_low = 1'b1; low_col = 2'd2; end
      4'b0111: begin one_low = 1'b1; low_col = 2'd3; end
      default: ;
    endcase
  end

  assign match = (col_s_q == ~(4'b0001 << cand_q));

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cand_d   = cand_q;
    deb_d    = deb_q;
    kb_idx_d = kb_idx_q;
    div_d    = tick ? '0 : div_q + DIV_W'(1);
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (any_low) begin
            state_d = SCAN;
            row_d   = 2'd0;
          end
        end
        SCAN: begin
          if (one_low) begin
            cand_d  = low_col;
            deb_d   = '0;
            state_d = DEBOUNCE;
          end else if (any_low) begin
            state_d = IDLE;
          end else if (row_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!match) begin
            state_d = IDLE;
          end else if (deb_q == DEB_LAST) begin
            state_d  = PRESSED;
            kb_idx_d = {1'b1, key_code(row_q, cand_q)};
            deb_d    = '0;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end
        PRESSED: begin
          // Any matching tick restarts the release count, so only a clean release ends the hold.
          if (match) begin
            deb_d = '0;
          end else if (deb_q == DEB_LAST) begin
            kb_idx_d[4] = 1'b0;
            deb_d       = '0;
            state_d     = IDLE;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    row_out_d = (state_d == IDLE) ? 4'b0000 : ~(4'b0001 << row_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 4'hF;
      col_s_q   <= 4'hF;
      div_q     <= '0;
      state_q   <= IDLE;
      row_q     <= 2'd0;
      cand_q    <= 2'd0;
      deb_q     <= '0;
      row_out_q <= 4'hF;
      kb_idx_q  <= '0;
    end else begin
      sync1_q   <= col_in;
      col_s_q   <= sync1_q;
      div_q     <= div_d;
      state_q   <= state_d;
      row_q     <= row_d;
      cand_q    <= cand_d;
      deb_q     <= deb_d;
      row_out_q <= row_out_d;
      kb_idx_q  <= kb_idx_d;
    end
  end

  assign row_out = row_out_q;
  assign kb_idx  = kb_idx_q;

`ifdef KB_PULSE_EN
  logic press_q, press_d;

  always_comb begin
    press_d = kb_idx_d[4] & ~kb_idx_q[4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) press_q <= 1'b0;
    else        press_q <= press_d;
  end

  assign kb_press = press_q;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad short model, table-driven key vectors,
// multi-cycle corner sequences and randomized presses/taps against a key-map reference.
module tb_keypad_scanner;
  localparam int SCAN_DIV  = 4;
  localparam int DEB_CYC   = 3;
  localparam int PRESS_MAX = 2 + SCAN_DIV * (1 + 4 + DEB_CYC);

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [4:0]  kb_idx;
`ifdef KB_PULSE_EN
  logic        kb_press;
`endif
  logic [15:0] keys = '0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  last_code = 4'h0;

  typedef struct {
    int         key;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t       vecs[6];
  logic [3:0] code_map[16];

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_CYC(DEB_CYC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .col_in  (col_in),
    .row_out (row_out),
    .kb_idx  (kb_idx)
`ifdef KB_PULSE_EN
    ,
    .kb_press(kb_press)
`endif
  );

  always #5 clk = ~clk;

  // Pressed key at (r,c) shorts row r to column c; columns are pulled up otherwise.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_hi(output int lat);
    lat = 0;
    while (lat < 60 && kb_idx[4] !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_lo(output int lat);
    lat = 0;
    while (lat < 60 && kb_idx[4] !== 1'b0) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic watch(input int n, input logic [4:0] want, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (kb_idx !== want) bad++;
    end
  endtask

  task automatic press_release(input string name, input int key, input logic [4:0] exp);
    int lat;
    keys = '0;
    keys[key] = 1'b1;
    wait_hi(lat);
    chk({name, " press"}, kb_idx, exp);
    chk_rng({name, " press latency"}, lat, 1, PRESS_MAX);
    keys = '0;
    wait_lo(lat);
    chk({name, " release"}, kb_idx, {1'b0, exp[3:0]});
    chk_rng({name, " release latency"}, lat, 2 + 3 * SCAN_DIV - 3, 2 + 3 * SCAN_DIV);
    last_code = exp[3:0];
  endtask

  initial begin
    int lat, bad, tot, k, d, i;
    int pulses;

    code_map = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                 4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    vecs[0] = '{5,  5'h15, "key 5"};
    vecs[1] = '{12, 5'h1E, "key *"};
    vecs[2] = '{14, 5'h1F, "key #"};
    vecs[3] = '{15, 5'h1D, "key D"};
    vecs[4] = '{13, 5'h10, "key 0"};
    vecs[5] = '{3,  5'h1A, "key A"};

    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset row_out", row_out, 4'hF);
    chk("reset kb_idx", kb_idx, 5'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle row_out", row_out, 4'h0);

    for (int v = 0; v < 6; v++)
      press_release(vecs[v].name, vecs[v].key, vecs[v].exp);

    // Bounce on key 5: never stable long enough to be accepted.
    tot = 0;
    i = 0;
    while (i < 20) begin
      d = $urandom_range(1, 2);
      keys[5] = ~keys[5];
      watch(SCAN_DIV * d, {1'b0, last_code}, bad);
      tot += bad;
      i += d;
    end
    keys = '0;
    watch(40, {1'b0, last_code}, bad);
    tot += bad;
    chk("bounce no press", tot, 0);

    // Same-row pair is rejected as ghosting.
    keys = '0;
    keys[0] = 1'b1;
    keys[1] = 1'b1;
    watch(120, {1'b0, last_code}, bad);
    chk("keys 1+2 rejected", bad, 0);
    keys = '0;
    repeat (40) @(negedge clk);

    // Hold 7, add 3: the held key wins until both release.
    keys[8] = 1'b1;
    wait_hi(lat);
    chk("key 7 press", kb_idx, 5'h17);
    keys[2] = 1'b1;
    watch(60, 5'h17, bad);
    chk("key 7 held with 3 added", bad, 0);
    keys = '0;
    wait_lo(lat);
    chk("keys 7+3 release", kb_idx, 5'h07);
    last_code = 4'h7;

    for (int it = 0; it < 12; it++) begin
      k = $urandom_range(0, 15);
      keys = '0;
      if ($urandom_range(0, 3) == 0) begin
        keys[k] = 1'b1;
        repeat ($urandom_range(1, 8)) @(negedge clk);
        keys = '0;
        watch(40, {1'b0, last_code}, bad);
        chk("random tap ignored", bad, 0);
      end else begin
        keys[k] = 1'b1;
        wait_hi(lat);
        chk("random press", kb_idx, {1'b1, code_map[k]});
        chk_rng("random press latency", lat, 1, PRESS_MAX);
        watch($urandom_range(0, 40), {1'b1, code_map[k]}, bad);
        chk("random hold", bad, 0);
        keys = '0;
        wait_lo(lat);
        chk("random release", kb_idx, {1'b0, code_map[k]});
        last_code = code_map[k];
      end
    end

`ifdef KB_PULSE_EN
    pulses = 0;
    keys = '0;
    keys[10] = 1'b1;
    i = 0;
    while (i < 60 && kb_idx[4] !== 1'b1) begin
      @(negedge clk);
      if (kb_press === 1'b1) pulses++;
      i++;
    end
    chk("key 9 press", kb_idx, 5'h19);
    chk("kb_press with rise", kb_press, 1'b1);
    for (int j = 0; j < 100 * SCAN_DIV; j++) begin
      @(negedge clk);
      if (kb_press === 1'b1) pulses++;
    end
    keys = '0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (kb_press === 1'b1) pulses++;
    end
    chk("kb_press pulse count", pulses, 1);
    chk("key 9 release", kb_idx, 5'h09);
    last_code = 4'h9;
`endif

    // Asynchronous reset while key 5 is held.
    keys = '0;
    keys[5] = 1'b1;
    wait_hi(lat);
    chk("key 5 held before reset", kb_idx, 5'h15);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset row_out", row_out, 4'hF);
    chk("async reset kb_idx", kb_idx, 5'h00);
    keys = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
